// File: rtl/branch_pkg.sv
// Shared types for the branch resolve queue: BHT/PC width defaults, queue entry, flush-control states.
package branch_pkg;

    localparam int LOWER_DEF = 5;
    localparam int PC_W_DEF  = 32;

    typedef struct packed {
        logic [LOWER_DEF-1:0] idx;
        logic                 taken;
        logic [PC_W_DEF-1:0]  target;
        logic [PC_W_DEF-1:0]  fallthru;
    } brq_entry_t;

    typedef enum logic {
        IDLE,
        TRACK
    } brq_state_t;

endpackage

// File: rtl/brq_fifo_mem.sv
// Entry storage for the branch resolve queue: one write port, combinational head read, whole-array flush.
module brq_fifo_mem
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  brq_entry_t    wdata,
    input  logic [PW-1:0] raddr,
    output brq_entry_t    head
);

    brq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign head = mem_q[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch prediction tracker: resolves against execute, drives BHT updates and mispredict redirects.
// Optional BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int LOWER = LOWER_DEF,
    parameter int DEPTH = 4,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic [LOWER-1:0]         pred_idx,
    input  logic                     pred_taken,
    input  logic [PC_W-1:0]          pred_target,
    input  logic [PC_W-1:0]          pred_fallthru,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_target,
    output logic                     bht_en,
    output logic [LOWER-1:0]         bht_write_addr,
    output logic                     bht_was_taken,
    output logic                     mispredict,
    output logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispred
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    brq_state_t       state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             bht_en_q, was_taken_q, mis_q, underflow_q;
    logic [LOWER-1:0] bht_addr_q;
    logic [PC_W-1:0]  redirect_q;

    brq_entry_t head, wentry;
    logic full, res_ok, push_ok, mis, flush, wr_en;

    assign full    = (count_q == CW'(DEPTH));
    assign res_ok  = en && res_valid && (state_q == TRACK);
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign push_ok = en && pred_valid && (!full || res_ok);
    assign mis     = (res_taken != head.taken) || (res_taken && (res_target != head.target));
    assign flush   = res_ok && mis;
    assign wr_en   = push_ok && !flush;

    always_comb begin
        wentry          = '0;
        wentry.idx      = pred_idx;
        wentry.taken    = pred_taken;
        wentry.target   = pred_target;
        wentry.fallthru = pred_fallthru;
    end

    brq_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wentry),
        .raddr (rd_ptr_q),
        .head  (head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_en)  wr_ptr_d = wr_ptr_q + PW'(1);
            if (res_ok) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(wr_en) - CW'(res_ok);
        end
        case (state_q)
            IDLE:    if (wr_en) state_d = TRACK;
            TRACK:   if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bht_en_q    <= 1'b0;
            bht_addr_q  <= '0;
            was_taken_q <= 1'b0;
            mis_q       <= 1'b0;
            redirect_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            bht_en_q    <= res_ok;
            bht_addr_q  <= res_ok ? head.idx : '0;
            was_taken_q <= res_ok && res_taken;
            mis_q       <= flush;
            redirect_q  <= flush ? (res_taken ? res_target : head.fallthru) : '0;
            if (en && res_valid && (state_q == IDLE)) underflow_q <= 1'b1;
        end
    end

    // A stall suppresses the strobes in the cycle it is asserted.
    assign bht_en         = bht_en_q && en;
    assign mispredict     = mis_q && en;
    assign redirect_pc    = en ? redirect_q : '0;
    assign bht_write_addr = bht_addr_q;
    assign bht_was_taken  = was_taken_q;
    assign pred_ready     = !full;
    assign count          = count_q;
    assign empty          = (state_q == IDLE);
    assign underflow      = underflow_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_res_q, stat_mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (res_ok && (stat_res_q != '1)) stat_res_q <= stat_res_q + 32'd1;
            if (flush && (stat_mis_q != '1))  stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_resolved = stat_res_q;
    assign stat_mispred  = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, en, pred_valid, pred_taken, res_valid, res_taken;
    logic [4:0]  pred_idx;
    logic [31:0] pred_target, pred_fallthru, res_target;
    logic        pred_ready, bht_en, bht_was_taken, mispredict, empty, underflow;
    logic [4:0]  bht_write_addr;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_resolved, stat_mispred;
`endif

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_idx       (pred_idx),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_fallthru  (pred_fallthru),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .bht_en         (bht_en),
        .bht_write_addr (bht_write_addr),
        .bht_was_taken  (bht_was_taken),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .count          (count),
        .empty          (empty),
        .underflow      (underflow)
`ifdef BRQ_STATS_EN
        ,
        .stat_resolved  (stat_resolved),
        .stat_mispred   (stat_mispred)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of predictions plus the last-cycle result pulse.
    typedef struct {
        logic [4:0]  idx;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] ft;
    } ent_t;

    ent_t        mq[$];
    logic        m_bht, m_was, m_mis, m_uf;
    logic [4:0]  m_addr;
    logic [31:0] m_redir;
    int unsigned m_sres, m_smis;

    task automatic model_step();
        ent_t h, e;
        bit   popped, wrong, was_full;
        popped = 0;
        wrong  = 0;
        m_bht = 0; m_was = 0; m_mis = 0; m_addr = 0; m_redir = 0;
        if (rst) begin
            mq.delete();
            m_uf = 0; m_sres = 0; m_smis = 0;
        end else if (en) begin
            was_full = (mq.size() == DEPTH);
            if (res_valid) begin
                if (mq.size() == 0) begin
                    m_uf = 1;
                end else begin
                    h = mq.pop_front();
                    popped = 1;
                    wrong = (res_taken != h.taken) || (res_taken && res_target != h.tgt);
                    m_bht = 1; m_addr = h.idx; m_was = res_taken; m_mis = wrong;
                    m_redir = wrong ? (res_taken ? res_target : h.ft) : 32'd0;
                    if (m_sres != 32'hFFFF_FFFF) m_sres++;
                    if (wrong) begin
                        mq.delete();
                        if (m_smis != 32'hFFFF_FFFF) m_smis++;
                    end
                end
            end
            if (pred_valid && (!was_full || popped) && !wrong) begin
                e.idx = pred_idx; e.taken = pred_taken; e.tgt = pred_target; e.ft = pred_fallthru;
                mq.push_back(e);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            chk("count",       64'(count),          64'(mq.size()));
            chk("empty",       64'(empty),          64'(mq.size() == 0));
            chk("pred_ready",  64'(pred_ready),     64'(mq.size() != DEPTH));
            chk("bht_en",      64'(bht_en),         64'(m_bht && en));
            chk("bht_addr",    64'(bht_write_addr), 64'(m_addr));
            chk("bht_taken",   64'(bht_was_taken),  64'(m_was));
            chk("mispredict",  64'(mispredict),     64'(m_mis && en));
            chk("redirect_pc", 64'(redirect_pc),    64'(en ? m_redir : 32'd0));
            chk("underflow",   64'(underflow),      64'(m_uf));
`ifdef BRQ_STATS_EN
            chk("stat_res",    64'(stat_resolved),  64'(m_sres));
            chk("stat_mis",    64'(stat_mispred),   64'(m_smis));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] idx, input logic tk, input logic [31:0] tgt, input logic [31:0] ft);
        pred_valid = 1; pred_idx = idx; pred_taken = tk; pred_target = tgt; pred_fallthru = ft;
    endtask

    initial begin
        rst = 1; en = 1; pred_valid = 0; pred_idx = 0; pred_taken = 0; pred_target = 0;
        pred_fallthru = 0; res_valid = 0; res_taken = 0; res_target = 0;
        tick();
        cmp_on = 1;
        tick();
        rst = 0;
        tick();
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_ready", 64'(pred_ready), 64'd1);
        chk("t1_bht",   64'(bht_en), 64'd0);
        chk("t1_mis",   64'(mispredict), 64'd0);

        // correct prediction
        push(5'd5, 1, 32'h40, 32'h14); tick();
        pred_valid = 0; res_valid = 1; res_taken = 1; res_target = 32'h40; tick();
        res_valid = 0;
        chk("t2_bht",   64'(bht_en), 64'd1);
        chk("t2_addr",  64'(bht_write_addr), 64'd5);
        chk("t2_taken", 64'(bht_was_taken), 64'd1);
        chk("t2_mis",   64'(mispredict), 64'd0);
        chk("t2_count", 64'(count), 64'd0);

        // direction mispredict with a same-cycle push that must be dropped
        push(5'd3, 0, 32'h100, 32'h10); tick();
        push(5'd7, 0, 32'h100, 32'h20); tick();
        push(5'd9, 0, 32'h100, 32'h30); tick();
        push(5'd11, 0, 32'h0, 32'h0);
        res_valid = 1; res_taken = 1; res_target = 32'h80; tick();
        pred_valid = 0; res_valid = 0;
        chk("t3_mis",   64'(mispredict), 64'd1);
        chk("t3_redir", 64'(redirect_pc), 64'h80);
        chk("t3_addr",  64'(bht_write_addr), 64'd3);
        chk("t3_count", 64'(count), 64'd0);
        tick();
        chk("t3_pulse_drop", 64'(mispredict), 64'd0);

        // target mispredict
        push(5'd2, 1, 32'h40, 32'h8); tick();
        pred_valid = 0; res_valid = 1; res_taken = 1; res_target = 32'h44; tick();
        res_valid = 0;
        chk("t4_mis",   64'(mispredict), 64'd1);
        chk("t4_redir", 64'(redirect_pc), 64'h44);

        // fill, then push+resolve across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            push(5'(10 + i), 0, 32'h0, 32'(16 * i)); tick();
        end
        pred_valid = 0;
        chk("t5_ready", 64'(pred_ready), 64'd0);
        for (int i = 0; i < 6; i++) begin
            push(5'(14 + i), 0, 32'h0, 32'h0);
            res_valid = 1; res_taken = 0; res_target = 32'h0; tick();
            chk("t5_count", 64'(count), 64'd4);
            chk("t5_order", 64'(bht_write_addr), 64'(10 + i));
        end
        pred_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        res_valid = 0;
        chk("t5_drained", 64'(count), 64'd0);

        // resolve while empty, then stalled resolve
        res_valid = 1; tick();
        res_valid = 0;
        chk("t6_uf",  64'(underflow), 64'd1);
        chk("t6_bht", 64'(bht_en), 64'd0);
        push(5'd1, 0, 32'h0, 32'h4); tick();
        pred_valid = 0; en = 0; res_valid = 1; tick();
        chk("t6_stall_count", 64'(count), 64'd1);
        chk("t6_stall_bht",   64'(bht_en), 64'd0);
        en = 1; res_valid = 0; tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            en         = ($urandom_range(0, 9) != 0);
            pred_valid = $urandom_range(0, 1) == 1;
            pred_idx   = 5'($urandom_range(0, 31));
            pred_taken = $urandom_range(0, 1) == 1;
            pred_target   = $urandom_range(0, 1) == 1 ? 32'h40 : 32'h44;
            pred_fallthru = 32'($urandom_range(0, 255)) << 2;
            res_valid  = ($urandom_range(0, 9) < 4);
            res_taken  = $urandom_range(0, 1) == 1;
            res_target = ($urandom_range(0, 3) != 0) ? 32'h40 : 32'h44;
            tick();
        end
        rst = 0; en = 1; pred_valid = 0; res_valid = 0;
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
